// File: rtl/ccg_tt_pkg.sv
// Shared types and constants for the ccg_tt truth-table capture engine.
// The MISR constants are only consumed when CCG_TT_MISR_EN is defined.
package ccg_tt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_EMIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int          SIG_W     = 16;
    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'h0000;

    // One MISR step: shift left, fold the polynomial on carry-out, absorb the row.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                   input logic [SIG_W-1:0] data);
        return {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? MISR_POLY : '0) ^ data;
    endfunction

endpackage

// File: rtl/ccg_tt_capture_misr.sv
// 16-bit MISR compacting accepted truth-table rows into a signature.
// Instantiated by ccg_tt_capture only when CCG_TT_MISR_EN is defined.
module ccg_tt_misr
    import ccg_tt_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [SIG_W-1:0] i_data,
    output logic [SIG_W-1:0] o_sig
);

    logic [SIG_W-1:0] r_sig;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_sig <= MISR_SEED;
        end else if (i_en) begin
            r_sig <= misr_step(r_sig, i_data);
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/ccg_tt_capture.sv
// Truth-table capture engine: sweeps every CUT input vector and streams back rows.
// Optional signature compaction is enabled by defining CCG_TT_MISR_EN.
module ccg_tt_capture
    import ccg_tt_pkg::*;
#(
    parameter int N_IN   = 6,
    parameter int N_OUT  = 6,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N_IN-1:0]  x,
    input  logic [N_OUT-1:0] f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_IN-1:0]  out_idx,
    output logic [N_OUT-1:0] out_data,
    output logic             busy,
    output logic             done
`ifdef CCG_TT_MISR_EN
    ,
    output logic [SIG_W-1:0] signature
`endif
);

    localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);
    localparam logic [N_IN-1:0] LAST_IDX   = '1;

    state_t           r_state, w_state;
    logic [N_IN-1:0]  r_idx, w_idx;
    logic [3:0]       r_cnt, w_cnt;
    logic             r_valid, w_valid;
    logic [N_IN-1:0]  r_out_idx, w_out_idx;
    logic [N_OUT-1:0] r_out_data, w_out_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_out_idx  <= '0;
            r_out_data <= '0;
        end else begin
            r_state    <= w_state;
            r_idx      <= w_idx;
            r_cnt      <= w_cnt;
            r_valid    <= w_valid;
            r_out_idx  <= w_out_idx;
            r_out_data <= w_out_data;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_idx      = r_idx;
        w_cnt      = r_cnt;
        w_valid    = r_valid;
        w_out_idx  = r_out_idx;
        w_out_data = r_out_data;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state = ST_SETTLE;
                    w_idx   = '0;
                    w_cnt   = SETTLE_CNT;
                end
            end
            ST_SETTLE: begin
                if (r_cnt != 4'd0) begin
                    w_cnt = r_cnt - 4'd1;
                end else begin
                    w_out_data = f;
                    w_out_idx  = r_idx;
                    w_valid    = 1'b1;
                    w_state    = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (r_valid && out_ready) begin
                    w_valid = 1'b0;
                    // Explicit terminal compare: the index never wraps back to row 0.
                    if (r_idx == LAST_IDX) begin
                        w_idx   = '0;
                        w_state = ST_DONE;
                    end else begin
                        w_idx   = r_idx + 1'b1;
                        w_cnt   = SETTLE_CNT;
                        w_state = ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign x         = r_idx;
    assign out_valid = r_valid;
    assign out_idx   = r_out_idx;
    assign out_data  = r_out_data;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);

`ifdef CCG_TT_MISR_EN
    logic             w_misr_clear;
    logic             w_misr_en;
    logic [SIG_W-1:0] w_misr_data;

    assign w_misr_clear = (r_state == ST_IDLE) && start;
    assign w_misr_en    = (r_state == ST_EMIT) && r_valid && out_ready;
    assign w_misr_data  = SIG_W'(r_out_data);

    ccg_tt_misr u_misr (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_misr_clear),
        .i_en    (w_misr_en),
        .i_data  (w_misr_data),
        .o_sig   (signature)
    );
`endif

endmodule

// File: doc/ccg_tt_capture.md
# ccg_tt_capture

Sequential truth-table capture engine for generated combinational circuits. It sweeps every input vector of a combinational circuit-under-test (CUT) and samples the CUT's outputs after a programmable settle time. Each captured row is streamed out over a valid/ready interface. It sits on the read side of a generated netlist: the CUT consumes the `x` bus and returns the `f` bus, and this block reads the function back as labelled rows for dataset checking.

## Interface
- `N_IN`, 6: CUT input count; the sweep covers 2^N_IN rows.
- `N_OUT`, 6: CUT output count, with 1 ≤ N_OUT ≤ 16.
- `SETTLE`, 1: wait cycles between driving `x` and sampling `f`; range 0..15.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: pulse that begins a sweep; honoured only in IDLE.
- `x` output N_IN: registered stimulus driven to the CUT.
- `f` input N_OUT: CUT response.
- `out_valid` output 1: a captured row is available.
- `out_ready` input 1: downstream accepts the row.
- `out_idx` output N_IN: input vector of the current row.
- `out_data` output N_OUT: captured `f` for that row.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse after the last row is accepted.
- `signature` output 16: MISR result; present only with `CCG_TT_MISR_EN`.

## Operation
- **Reset values.** All registers reset to zero: state = IDLE, `x` = 0, `out_valid` = 0, `out_idx` = 0, `out_data` = 0, `busy` = 0, `done` = 0, `signature` = 0. Reset wins over every other event.
- **IDLE**
  - On `start`: go to SETTLE with idx = 0, `x` = 0, and the settle counter loaded with SETTLE.
- **SETTLE**
  - Counter nonzero: decrement it and hold `x`.
  - Counter zero: at that edge, latch `out_data` = f and `out_idx` = idx, set `out_valid` = 1, and go to EMIT.
- **EMIT**
  - `out_valid` stays high and `out_idx`/`out_data` stay stable until `out_ready`.
  - On handshake (`out_valid` && `out_ready`) with idx = 2^N_IN−1:
    - clear `out_valid`;
    - go to DONE;
    - set `x` = 0.
  - On handshake otherwise:
    - clear `out_valid`;
    - idx = idx+1 and `x` = idx+1;
    - reload the counter;
    - go to SETTLE.
- **DONE**
  - `done` = 1 for exactly one cycle, then go to IDLE.
- **Counter arithmetic.** idx is N_IN bits wide with an explicit terminal compare. There is no wrap to 0 and no row is emitted twice.
- **`start` outside IDLE.** Ignored, including in DONE.
- **`out_ready` outside EMIT.** No effect.
- **Reset mid-sweep.** The next cycle is IDLE with all outputs at reset values. The partial sweep is discarded and no `done` pulse is produced.

## Timing
- `start` is sampled at edge 0, and `x` = 0 is visible after edge 0.
- `f` is sampled at edge SETTLE+1 and `out_valid` rises after that edge. With SETTLE = 0, `f` is sampled one cycle after `x` changes.
- Row-to-row spacing with `out_ready` held high is SETTLE+2 cycles.
- A full sweep takes 2^N_IN·(SETTLE+2) cycles, plus 1 cycle for the DONE state.
- `done` is asserted in the cycle after the final handshake edge.
- Outputs are registered; there is no combinational path from `f` or `out_ready` to any output.

## Configuration
- **Macro `CCG_TT_MISR_EN`.**
- **Defined:**
  - A 16-bit MISR with polynomial 0x1021 and seed 0x0000 updates once per accepted row.
  - Update rule: sig ← (sig<<1) ^ (sig[15] ? 0x1021 : 0) ^ zero-extended out_data.
  - `signature` is valid when `done` pulses and holds until the next `start`, which clears it to 0.
- **Undefined:** no MISR logic and no `signature` port.

## Structure
- **Package `ccg_tt_pkg`:**
  - state enum (IDLE, SETTLE, EMIT, DONE);
  - `MISR_POLY` = 16'h1021;
  - `MISR_SEED` = 16'h0000;
  - `SIG_W` = 16.
- **Sub-module `ccg_tt_misr`:** clear, enable, data and sig ports, instantiated under the macro. The FSM and counters stay in the top module.

## Test plan
- **Identity loopback** (f = x, SETTLE = 1, `out_ready` = 1): 64 rows with out_data == out_idx for 0..63, rows 3 cycles apart, then a single `done` pulse and `busy` = 0.
- **Inverting loopback** (f = ~x): row 5 gives out_data = 6'h3A; row 63 gives 6'h00.
- **Backpressure:** hold `out_ready` low for 5 cycles while out_idx = 3. Then `out_valid` stays 1 with out_idx/out_data stable at 3, `x` stays at 3, and row 4 follows the release.
- **Reset mid-sweep:** assert `rst` while out_idx = 10. The next cycle shows `x` = 0, `out_valid` = 0 and `busy` = 0, with no `done`. A following `start` begins again at idx 0.
- **`start` during sweep and SETTLE = 0:** a `start` during the sweep is ignored. With SETTLE = 0, rows are 2 cycles apart, and `f` sampled one cycle after `x` is the value reported.
- **MISR, with `CCG_TT_MISR_EN`:**
  - f tied to 0: `signature` = 16'h0000 at `done`.
  - Identity loopback: `signature` matches the golden-model value, and the same value is returned on a second sweep.
